// File: rtl/uart_reg_master_pkg.sv
// Shared constants for the UART-driven register bus master: command and reply
// codes plus the FSM state encoding.
package uart_reg_master_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h00;
   localparam logic [7:0] CMD_READ  = 8'h80;
   localparam logic [7:0] RSP_OK    = 8'hA5;
   localparam logic [7:0] RSP_ERR   = 8'hEE;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE      = 4'd0;
   localparam state_t ST_ADDR      = 4'd1;
   localparam state_t ST_LEN       = 4'd2;
   localparam state_t ST_WR_DATA   = 4'd3;
   localparam state_t ST_WR_STROBE = 4'd4;
   localparam state_t ST_RD_STROBE = 4'd5;
   localparam state_t ST_RD_WAIT   = 4'd6;
   localparam state_t ST_RD_SEND   = 4'd7;
   localparam state_t ST_STATUS    = 4'd8;
   localparam state_t ST_ERR       = 4'd9;

   // States in which the master is waiting on a command byte.
   function automatic logic is_byte_wait(input state_t s);
      return (s == ST_ADDR) || (s == ST_LEN) || (s == ST_WR_DATA);
   endfunction

   // States between address capture and the end of the frame's last access.
   function automatic logic is_addr_phase(input state_t s);
      return (s == ST_LEN) || (s == ST_WR_DATA) || (s == ST_WR_STROBE) ||
             (s == ST_RD_STROBE) || (s == ST_RD_WAIT) || (s == ST_RD_SEND);
   endfunction

endpackage

// File: rtl/rms_timeout.sv
// Reloadable inter-byte timeout counter; only instantiated by uart_reg_master
// when RMS_TIMEOUT_EN is defined.
module rms_timeout #(
   parameter int pTIMEOUT = 1000
) (
   input  logic usb_clk,
   input  logic reset_n,
   input  logic reload,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(pTIMEOUT + 1);

   logic [W-1:0] count;

   always_ff @(posedge usb_clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= W'(pTIMEOUT);
      end else if (reload) begin
         count <= W'(pTIMEOUT);
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expired = enable && (count == '0);

endmodule

// File: rtl/uart_reg_master.sv
// Byte-command framed register bus master (CMD, ADDR, LEN, [data...]).
// Optional inter-byte timeout abort is enabled with `define RMS_TIMEOUT_EN.
module uart_reg_master
   import uart_reg_master_pkg::*;
#(
   parameter int pBYTECNT_SIZE = 7,
   parameter int pRD_LATENCY   = 1,
   parameter int pTIMEOUT      = 1000
) (
   input  logic                     usb_clk,
   input  logic                     reset_n,
   input  logic [7:0]               I_cmd_data,
   input  logic                     I_cmd_valid,
   output logic                     O_cmd_ready,
   output logic [7:0]               O_rsp_data,
   output logic                     O_rsp_valid,
   input  logic                     I_rsp_ready,
   output logic [7:0]               reg_address,
   output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
   output logic [7:0]               write_data,
   input  logic [7:0]               read_data,
   output logic                     reg_read,
   output logic                     reg_write,
   output logic                     reg_addrvalid
);

   state_t      state;
   logic        run;
   logic        is_read;
   logic [7:0]  remaining;
   logic [1:0]  wait_cnt;
   logic [7:0]  rd_sample;
   logic        cmd_fire;
   logic        rsp_fire;
   logic        timeout_hit;

   // NOTE: strobes and valids are decoded from the state register, so the
   // asynchronous reset forces them low immediately, even mid-frame.
   assign reg_write     = (state == ST_WR_STROBE);
   assign reg_read      = (state == ST_RD_STROBE);
   assign reg_addrvalid = is_addr_phase(state);
   assign O_rsp_valid   = (state == ST_RD_SEND) || (state == ST_STATUS) || (state == ST_ERR);
   assign O_cmd_ready   = run && ((state == ST_IDLE) || is_byte_wait(state));

   always_comb begin
      O_rsp_data = 8'h00;
      case (state)
         ST_RD_SEND: O_rsp_data = rd_sample;
         ST_STATUS:  O_rsp_data = RSP_OK;
         ST_ERR:     O_rsp_data = RSP_ERR;
         default:    O_rsp_data = 8'h00;
      endcase
   end

   assign cmd_fire = I_cmd_valid && O_cmd_ready;
   assign rsp_fire = O_rsp_valid && I_rsp_ready;

`ifdef RMS_TIMEOUT_EN
   rms_timeout #(
      .pTIMEOUT (pTIMEOUT)
   ) u_timeout (
      .usb_clk (usb_clk),
      .reset_n (reset_n),
      .reload  (cmd_fire || !is_byte_wait(state)),
      .enable  (is_byte_wait(state)),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // NOTE: all sequential state uses non-blocking assignments so every branch
   // sees the pre-edge values of state, remaining and reg_bytecnt.
   always_ff @(posedge usb_clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         run         <= 1'b0;
         is_read     <= 1'b0;
         reg_address <= 8'h00;
         reg_bytecnt <= '0;
         write_data  <= 8'h00;
         remaining   <= 8'h00;
         wait_cnt    <= 2'd0;
         rd_sample   <= 8'h00;
      end else begin
         run <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (cmd_fire) begin
                  is_read <= (I_cmd_data == CMD_READ);
                  if ((I_cmd_data == CMD_WRITE) || (I_cmd_data == CMD_READ)) state <= ST_ADDR;
                  else                                                      state <= ST_ERR;
               end
            end
            ST_ADDR: begin
               if (cmd_fire) begin
                  reg_address <= I_cmd_data;
                  reg_bytecnt <= '0;
                  state       <= ST_LEN;
               end else if (timeout_hit) begin
                  state <= ST_ERR;
               end
            end
            ST_LEN: begin
               if (cmd_fire) begin
                  remaining <= I_cmd_data;
                  // A zero-length write still acknowledges; a zero-length read is silent.
                  if (I_cmd_data == 8'h00) state <= is_read ? ST_IDLE : ST_STATUS;
                  else                     state <= is_read ? ST_RD_STROBE : ST_WR_DATA;
               end else if (timeout_hit) begin
                  state <= ST_ERR;
               end
            end
            ST_WR_DATA: begin
               if (cmd_fire) begin
                  write_data <= I_cmd_data;
                  state      <= ST_WR_STROBE;
               end else if (timeout_hit) begin
                  state <= ST_ERR;
               end
            end
            ST_WR_STROBE: begin
               reg_bytecnt <= reg_bytecnt + 1'b1;
               remaining   <= remaining - 8'd1;
               state       <= (remaining == 8'd1) ? ST_STATUS : ST_WR_DATA;
            end
            ST_RD_STROBE: begin
               wait_cnt <= 2'd0;
               state    <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               if (wait_cnt == 2'(pRD_LATENCY - 1)) begin
                  rd_sample <= read_data;
                  state     <= ST_RD_SEND;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            ST_RD_SEND: begin
               if (rsp_fire) begin
                  reg_bytecnt <= reg_bytecnt + 1'b1;
                  remaining   <= remaining - 8'd1;
                  state       <= (remaining == 8'd1) ? ST_IDLE : ST_RD_STROBE;
               end
            end
            ST_STATUS, ST_ERR: begin
               if (rsp_fire) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
